// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning path, so the debouncer,
// btn_module and the benches agree on the button count and state encoding.
//   N_BTN_DEFAULT : default number of button channels
//   chan_state_e  : per-channel debounce state encoding
//   cnt_width()   : width needed for the shared debounce/repeat counters
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int N_BTN_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_UP_CHK   = 2'd1,
    ST_DOWN     = 2'd2,
    ST_DOWN_CHK = 2'd3
  } chan_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Wide enough to hold the largest terminal count of any channel counter.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
// Bundles the button signals between the pads/bench and the debouncer.
//   btn_raw   : raw pad inputs, asynchronous, 1 = pressed
//   btn_level : debounced level, 1 = pressed
//   btn_press : one-cycle pulse per accepted press (and repeat)
//   any_press : OR of btn_press, registered alongside it
// master = the side driving the raw pads, slave = the debouncer.
// -----------------------------------------------------------------------------
interface btn_debounce_if #(
  parameter int N_BTN = btn_pkg::N_BTN_DEFAULT
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output any_press
  );

endinterface

// File: rtl/btn_debounce_chan.sv
// -----------------------------------------------------------------------------
// btn_debounce_chan
// One button channel: 2-flop synchronizer, stability counter and the
// UP / UP_CHK / DOWN / DOWN_CHK debounce FSM, plus optional auto-repeat.
//   clk          : system clock
//   rst          : synchronous reset, active-high
//   raw_i        : raw pad input, asynchronous
//   level_o      : debounced level (registered)
//   press_o      : one-cycle press/repeat pulse (registered)
//   press_next_o : value press_o takes at the next edge, lets the top
//                  register any_press in the same cycle as press_o
// Optional feature: define AUTO_REPEAT_EN to emit repeat pulses while held.
// -----------------------------------------------------------------------------
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic press_next_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             s_sync;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
`endif

  assign s_sync = sync_q[1];

  // Next-state logic: synchronizer shift, debounce FSM and optional repeat timer.
  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;

    // cnt counts consecutive cycles the synchronized input has held its new value;
    // it is cleared on every transition so it never exceeds DB_LAST.
    case (state_q)
      ST_UP: begin
        if (s_sync) begin
          state_d = ST_UP_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_UP_CHK: begin
        if (!s_sync) begin
          state_d = ST_UP;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (!s_sync) begin
          state_d = ST_DOWN_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_DOWN_CHK: begin
        if (s_sync) begin
          state_d = ST_DOWN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_UP;
          level_d = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_UP;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    // rpt_cnt counts cycles since the last pulse; rpt_first selects whether the
    // initial delay or the steady period is being timed. It runs through bounces
    // (DOWN_CHK) and is cleared the moment the channel returns to UP.
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    if ((state_q == ST_UP_CHK) && (state_d == ST_DOWN)) begin
      rpt_cnt_d   = CNT_ZERO;
      rpt_first_d = 1'b1;
    end else if (((state_q == ST_DOWN) || (state_q == ST_DOWN_CHK)) &&
                 (state_d != ST_UP)) begin
      if (rpt_first_q ? (rpt_cnt_q == RPT_DELAY_LAST) : (rpt_cnt_q == RPT_PERIOD_LAST)) begin
        press_d     = 1'b1;
        rpt_cnt_d   = CNT_ZERO;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + CNT_ONE;
      end
    end else begin
      rpt_cnt_d   = CNT_ZERO;
      rpt_first_d = 1'b1;
    end
`endif
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= ST_UP;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      press_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q   <= CNT_ZERO;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  // During reset the pulse register is forced low, so the look-ahead must be too.
  assign press_next_o = press_d & ~rst;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions the raw board push-buttons: synchronize, debounce, and produce a
// clean level plus a one-cycle press pulse per button. Channels are fully
// independent; several may press in the same cycle.
//   clk            : system clock, rising edge
//   rst            : synchronous reset, active-high
//   bus.btn_raw    : raw pad inputs (in)
//   bus.btn_level  : debounced levels, feed btn_module.btn (out)
//   bus.btn_press  : one-cycle press pulses (out)
//   bus.any_press  : OR of btn_press, registered with it (out)
// Optional feature: define AUTO_REPEAT_EN for held-button repeat pulses.
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic          clk,
  input logic          rst,
  btn_debounce_if.slave bus
);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] press_next_s;
  logic             any_press_q, any_press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .raw_i        (bus.btn_raw[i]),
      .level_o      (level_s[i]),
      .press_o      (press_s[i]),
      .press_next_o (press_next_s[i])
    );
  end

  // Built from the channels' next-pulse values so any_press lines up with btn_press.
  always_comb begin
    any_press_d = |press_next_s;
  end

  // any_press register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign bus.btn_level = level_s;
  assign bus.btn_press = press_s;
  assign bus.any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Expected press pulses are queued with the cycle they must
// appear in; a negedge monitor pops them and checks btn_press/any_press every
// cycle. Levels and reset values are checked inline by the scenario tasks.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int NB  = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = 2 + DB;

  typedef struct {
    int             cyc;
    logic [NB-1:0]  mask;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  exp_t sb[$];

  btn_debounce_if #(.N_BTN(NB)) bus_if ();

  btn_debounce #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle, btn_press must equal the queued mask for
  // this cycle (or zero), and any_press must be its OR.
  always @(negedge clk) begin
    logic [NB-1:0] exp_mask;
    if (mon_en) begin
      exp_mask = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        exp_mask = sb[0].mask;
        void'(sb.pop_front());
      end
      checks++;
      if (bus_if.btn_press !== exp_mask) begin
        errors++;
        $display("FAIL press cyc=%0d actual=%b expected=%b", cyc, bus_if.btn_press, exp_mask);
      end
      checks++;
      if (bus_if.any_press !== (|exp_mask)) begin
        errors++;
        $display("FAIL any_press cyc=%0d actual=%b expected=%b", cyc, bus_if.any_press, |exp_mask);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [NB-1:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    int t;
    bus_if.btn_raw = 5'h1F;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.btn_level !== 5'h00 || bus_if.btn_press !== 5'h00 || bus_if.any_press !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b/%b/%b expected=0/0/0",
               bus_if.btn_level, bus_if.btn_press, bus_if.any_press);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    t = cyc;
    push_exp(t + LAT, 5'h1F);
    wait_cyc(t + LAT - 1);
    checks++;
    if (bus_if.btn_level !== 5'h00) begin
      errors++;
      $display("FAIL held_through_rst_early actual=%b expected=%b", bus_if.btn_level, 5'h00);
    end
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'h1F) begin
      errors++;
      $display("FAIL held_through_rst_level actual=%b expected=%b", bus_if.btn_level, 5'h1F);
    end
    bus_if.btn_raw = 5'h00;
    t = cyc;
    wait_cyc(t + LAT - 1);
    checks++;
    if (bus_if.btn_level !== 5'h1F) begin
      errors++;
      $display("FAIL release_all_early actual=%b expected=%b", bus_if.btn_level, 5'h1F);
    end
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'h00) begin
      errors++;
      $display("FAIL release_all_level actual=%b expected=%b", bus_if.btn_level, 5'h00);
    end
    wait_cyc(t + LAT + 4);
  endtask

  task automatic test_single_press;
    int t;
    bus_if.btn_raw = 5'b00001;
    t = cyc;
    push_exp(t + LAT, 5'b00001);
    wait_cyc(t + LAT - 1);
    checks++;
    if (bus_if.btn_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_early actual=%b expected=0", bus_if.btn_level[0]);
    end
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'b00001) begin
      errors++;
      $display("FAIL single_level actual=%b expected=%b", bus_if.btn_level, 5'b00001);
    end
    bus_if.btn_raw = 5'b00000;
    wait_cyc(t + 2 * LAT + 4);
    checks++;
    if (bus_if.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL single_release actual=%b expected=%b", bus_if.btn_level, 5'b00000);
    end
  endtask

  task automatic test_bounce;
    int t;
    logic [4:0] pat;
    pat = 5'b10101;
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      bus_if.btn_raw[2] = pat[k];
      @(negedge clk);
    end
    // last 0->1 transition was driven at cycle t+4
    push_exp(t + 4 + LAT, 5'b00100);
    wait_cyc(t + 4 + LAT - 1);
    checks++;
    if (bus_if.btn_level[2] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_early actual=%b expected=0", bus_if.btn_level[2]);
    end
    wait_cyc(t + 4 + LAT);
    checks++;
    if (bus_if.btn_level !== 5'b00100) begin
      errors++;
      $display("FAIL bounce_level actual=%b expected=%b", bus_if.btn_level, 5'b00100);
    end
    bus_if.btn_raw = 5'b00000;
    wait_cyc(t + 4 + 2 * LAT + 4);
  endtask

  task automatic test_simultaneous;
    int t;
    bus_if.btn_raw = 5'b00111;
    t = cyc;
    push_exp(t + LAT, 5'b00111);
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'b00111) begin
      errors++;
      $display("FAIL simul_level actual=%b expected=%b", bus_if.btn_level, 5'b00111);
    end
    wait_cyc(t + LAT + 3);
    bus_if.btn_raw = 5'b00000;
    t = cyc;
    wait_cyc(t + LAT - 1);
    checks++;
    if (bus_if.btn_level !== 5'b00111) begin
      errors++;
      $display("FAIL simul_release_early actual=%b expected=%b", bus_if.btn_level, 5'b00111);
    end
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'b00000) begin
      errors++;
      $display("FAIL simul_release_level actual=%b expected=%b", bus_if.btn_level, 5'b00000);
    end
    wait_cyc(t + LAT + 4);
  endtask

  task automatic test_reset_mid_debounce;
    int t;
    bus_if.btn_raw = 5'b10000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.btn_level !== 5'h00 || bus_if.btn_press !== 5'h00 || bus_if.any_press !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs actual=%b/%b/%b expected=0/0/0",
               bus_if.btn_level, bus_if.btn_press, bus_if.any_press);
    end
    rst = 1'b0;
    t = cyc;
    push_exp(t + LAT, 5'b10000);
    wait_cyc(t + LAT - 1);
    checks++;
    if (bus_if.btn_level[4] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_early actual=%b expected=0", bus_if.btn_level[4]);
    end
    wait_cyc(t + LAT);
    checks++;
    if (bus_if.btn_level !== 5'b10000) begin
      errors++;
      $display("FAIL mid_rst_level actual=%b expected=%b", bus_if.btn_level, 5'b10000);
    end
    bus_if.btn_raw = 5'b00000;
    wait_cyc(t + 2 * LAT + 4);
  endtask

  task automatic test_repeat;
    int t0;
    bus_if.btn_raw = 5'b00010;
    t0 = cyc + LAT;
    push_exp(t0, 5'b00010);
`ifdef AUTO_REPEAT_EN
    push_exp(t0 + RD, 5'b00010);
    push_exp(t0 + RD + RP, 5'b00010);
    push_exp(t0 + RD + 2 * RP, 5'b00010);
`endif
    // Released so the channel returns to UP right after the last expected pulse.
    wait_cyc(t0 + RD + 1);
    bus_if.btn_raw = 5'b00000;
    wait_cyc(t0 + RD + 1 + LAT - 1);
    checks++;
    if (bus_if.btn_level[1] !== 1'b1) begin
      errors++;
      $display("FAIL repeat_held_level actual=%b expected=1", bus_if.btn_level[1]);
    end
    wait_cyc(t0 + RD + 1 + LAT);
    checks++;
    if (bus_if.btn_level[1] !== 1'b0) begin
      errors++;
      $display("FAIL repeat_release_level actual=%b expected=0", bus_if.btn_level[1]);
    end
    wait_cyc(t0 + RD + 1 + LAT + 2 * RD);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    bus_if.btn_raw = 5'h00;

    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_repeat();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
